// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: Avalon-ST frame receiver with a two-bank ping-pong store.
// The write side hunts for sop and validates framing and error flags. Only
// whole, clean frames are committed. The read side replays each committed
// bank with sop/eop and honours downstream backpressure.
module fft_frame_buffer #(
  parameter int DATA_W    = 12,
  parameter int FRAME_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sink_valid,
  output logic              sink_ready,
  input  logic              sink_sop,
  input  logic              sink_eop,
  input  logic [1:0]        sink_error,
  input  logic [DATA_W-1:0] sink_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic [DATA_W-1:0] src_data,
  output logic [7:0]        drop_count
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {W_HUNT, W_FILL} wr_state_e;
  typedef enum logic {R_IDLE, R_SEND} rd_state_e;

  // Frame storage: two banks, each holding one frame.
  logic [DATA_W-1:0] mem_q [2][FRAME_LEN];

  // Write side state
  wr_state_e          wstate_q, wstate_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic               bad_q, bad_d;
  logic               wr_bank_q, wr_bank_d;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic               commit;
  logic               drop;

  // Read side state
  rd_state_e          rstate_q, rstate_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic               rd_bank_q, rd_bank_d;
  logic               release_bank;

  // Shared bookkeeping and registered outputs
  logic [1:0]         committed_q, committed_d;
  logic               sink_ready_q, sink_ready_d;
  logic               src_valid_q, src_valid_d;
  logic               src_sop_q, src_sop_d;
  logic               src_eop_q, src_eop_d;
  logic [DATA_W-1:0]  src_data_q, src_data_d;
  logic [7:0]         drop_count_q, drop_count_d;

  logic accept;
  logic beat_err;

  assign accept   = sink_valid && sink_ready_q;
  assign beat_err = |sink_error;

  // Write FSM: frame hunting, framing checks, commit/drop decisions.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    wstate_d = wstate_q;
    widx_d   = widx_q;
    bad_d    = bad_q;
    wr_en    = 1'b0;
    wr_addr  = widx_q;
    commit   = 1'b0;
    drop     = 1'b0;
    unique case (wstate_q)
      W_HUNT: begin
        if (accept && sink_sop) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          if (sink_eop || beat_err) begin
            drop = 1'b1;
          end else begin
            wstate_d = W_FILL;
            widx_d   = IDX_W'(1);
            bad_d    = 1'b0;
          end
        end
      end
      W_FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (sink_sop) begin
            // Restart: abandon the partial frame and reuse this beat as index 0.
            drop    = 1'b1;
            wr_addr = '0;
            widx_d  = IDX_W'(1);
            bad_d   = beat_err || sink_eop;
          end else if (sink_eop) begin
            wstate_d = W_HUNT;
            if ((widx_q == LAST_IDX) && !(bad_q || beat_err)) commit = 1'b1;
            else                                              drop   = 1'b1;
          end else if (widx_q == LAST_IDX) begin
            // Frame overran its length without eop.
            drop     = 1'b1;
            wstate_d = W_HUNT;
          end else begin
            widx_d = widx_q + IDX_W'(1);
            bad_d  = bad_q || beat_err;
          end
        end
      end
      default: wstate_d = W_HUNT;
    endcase
  end

  assign wr_bank_d = wr_bank_q ^ commit;

  // Read FSM: replay committed banks, chaining banks without a bubble.
  always_comb begin
    rstate_d     = rstate_q;
    rd_idx_d     = rd_idx_q;
    rd_bank_d    = rd_bank_q;
    release_bank = 1'b0;
    src_valid_d  = src_valid_q;
    src_sop_d    = src_sop_q;
    src_eop_d    = src_eop_q;
    src_data_d   = src_data_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (committed_q[rd_bank_q]) begin
          rstate_d    = R_SEND;
          rd_idx_d    = '0;
          src_valid_d = 1'b1;
          src_sop_d   = 1'b1;
          src_eop_d   = 1'b0;
          src_data_d  = mem_q[rd_bank_q][0];
        end
      end
      R_SEND: begin
        if (src_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            release_bank = 1'b1;
            rd_bank_d    = ~rd_bank_q;
            if (committed_q[~rd_bank_q]) begin
              rd_idx_d   = '0;
              src_sop_d  = 1'b1;
              src_eop_d  = 1'b0;
              src_data_d = mem_q[~rd_bank_q][0];
            end else begin
              rstate_d    = R_IDLE;
              src_valid_d = 1'b0;
              src_sop_d   = 1'b0;
              src_eop_d   = 1'b0;
            end
          end else begin
            rd_idx_d   = rd_idx_q + IDX_W'(1);
            src_sop_d  = 1'b0;
            src_eop_d  = (rd_idx_q + IDX_W'(1)) == LAST_IDX;
            src_data_d = mem_q[rd_bank_q][rd_idx_q + IDX_W'(1)];
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Committed flags, sink_ready and drop counter next state.
  always_comb begin
    committed_d = committed_q;
    if (commit)       committed_d[wr_bank_q] = 1'b1;
    if (release_bank) committed_d[rd_bank_q] = 1'b0;
    // A release is seen one edge later; a commit always moves the writer to the other bank.
    sink_ready_d = ~committed_q[wr_bank_d];
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      wstate_q     <= W_HUNT;
      widx_q       <= '0;
      bad_q        <= 1'b0;
      wr_bank_q    <= 1'b0;
      rstate_q     <= R_IDLE;
      rd_idx_q     <= '0;
      rd_bank_q    <= 1'b0;
      committed_q  <= '0;
      sink_ready_q <= 1'b0;
      src_valid_q  <= 1'b0;
      src_sop_q    <= 1'b0;
      src_eop_q    <= 1'b0;
      src_data_q   <= '0;
      drop_count_q <= '0;
    end else begin
      wstate_q     <= wstate_d;
      widx_q       <= widx_d;
      bad_q        <= bad_d;
      wr_bank_q    <= wr_bank_d;
      rstate_q     <= rstate_d;
      rd_idx_q     <= rd_idx_d;
      rd_bank_q    <= rd_bank_d;
      committed_q  <= committed_d;
      sink_ready_q <= sink_ready_d;
      src_valid_q  <= src_valid_d;
      src_sop_q    <= src_sop_d;
      src_eop_q    <= src_eop_d;
      src_data_q   <= src_data_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Sample storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the sample memory has no reset; the committed flags alone decide what is valid.
    if (wr_en) mem_q[wr_bank_q][wr_addr] <= sink_data;
  end

  assign sink_ready = sink_ready_q;
  assign src_valid  = src_valid_q;
  assign src_sop    = src_sop_q;
  assign src_eop    = src_eop_q;
  assign src_data   = src_data_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Testbench for fft_frame_buffer. A scoreboard queue holds the beats expected
// from good frames, and an output monitor pops and compares them.
module tb_fft_frame_buffer;

  localparam int DATA_W    = 12;
  localparam int FRAME_LEN = 64;
  localparam int BUDGET    = 3000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sink_valid = 1'b0;
  logic              sink_ready;
  logic              sink_sop = 1'b0;
  logic              sink_eop = 1'b0;
  logic [1:0]        sink_error = 2'b00;
  logic [DATA_W-1:0] sink_data = '0;
  logic              src_valid;
  logic              src_ready = 1'b1;
  logic              src_sop;
  logic              src_eop;
  logic [DATA_W-1:0] src_data;
  logic [7:0]        drop_count;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    ready_mode = 0;  // 0: always ready, 1: held low, 2: alternating

  fft_frame_buffer #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .sink_valid (sink_valid),
    .sink_ready (sink_ready),
    .sink_sop   (sink_sop),
    .sink_eop   (sink_eop),
    .sink_error (sink_error),
    .sink_data  (sink_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .src_data   (src_data),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Downstream ready pattern, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       src_ready = 1'b1;
      1:       src_ready = 1'b0;
      default: src_ready = ~src_ready;
    endcase
  end

  // Output monitor: scoreboard pops on accepted beats, hold check while stalled.
  logic              hold_v = 1'b0;
  logic [DATA_W-1:0] hold_d;
  logic              hold_s, hold_e;
  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && src_valid) begin
        check("hold_data", src_data, hold_d);
        check("hold_sop",  src_sop,  hold_s);
        check("hold_eop",  src_eop,  hold_e);
      end
      if (src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", exp_q.size(), 1);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", src_data, e.data);
          check("out_sop",  src_sop,  e.sop);
          check("out_eop",  src_eop,  e.eop);
        end
      end
      hold_v = src_valid && !src_ready;
      hold_d = src_data;
      hold_s = src_sop;
      hold_e = src_eop;
    end
  end

  task automatic push_frame(input int base);
    beat_t b;
    for (int i = 0; i < FRAME_LEN; i++) begin
      b.data = DATA_W'(base + i);
      b.sop  = (i == 0);
      b.eop  = (i == FRAME_LEN - 1);
      exp_q.push_back(b);
    end
  endtask

  // Drive one beat and hold it until the DUT accepts it (bounded).
  task automatic send_beat(input int d, input logic sop, input logic eop, input logic [1:0] err);
    int waited;
    sink_data  = DATA_W'(d);
    sink_sop   = sop;
    sink_eop   = eop;
    sink_error = err;
    sink_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (sink_ready) break;
      waited++;
      if (waited > BUDGET) begin
        check("sink_timeout", waited, 0);
        sink_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    sink_error = 2'b00;
  endtask

  // n beats starting at base; sop on beat 0, eop on beat eop_at, error on beat err_at.
  task automatic send_frame(input int base, input int n, input int eop_at, input int err_at);
    for (int i = 0; i < n; i++)
      send_beat(base + i, i == 0, i == eop_at, (i == err_at) ? 2'b01 : 2'b00);
  endtask

  task automatic wait_drain(input string tag);
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || src_valid) && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Reset pulse with asynchronous-value checks and the first-edge sink_ready rise.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_src_valid",  src_valid,  0);
    check("rst_sink_ready", sink_ready, 0);
    check("rst_src_sop",    src_sop,    0);
    check("rst_src_eop",    src_eop,    0);
    check("rst_src_data",   src_data,   0);
    check("rst_drop_count", drop_count, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_ready_low", sink_ready, 0);
    @(posedge clk);
    #1;
    check("rel_ready_high", sink_ready, 1);
  endtask

  initial begin
    int waited;
    int n;
    logic seen;

    do_reset();

    // Test 1: clean frame, commit latency, drop_count stays 0.
    ready_mode = 0;
    push_frame(0);
    send_frame(0, FRAME_LEN, FRAME_LEN - 1, -1);
    check("t1_lat_before", src_valid, 0);
    @(posedge clk);
    #1;
    check("t1_lat_after", src_valid, 1);
    check("t1_first_sop", src_sop, 1);
    wait_drain("t1_drain");
    check("t1_drop", drop_count, 0);

    // Test 2: three frames with the output blocked, then alternating ready.
    do_reset();
    ready_mode = 1;
    push_frame(100);
    push_frame(200);
    push_frame(300);
    send_frame(100, FRAME_LEN, FRAME_LEN - 1, -1);
    send_frame(200, FRAME_LEN, FRAME_LEN - 1, -1);
    check("t2_full_ready", sink_ready, 0);
    fork
      send_frame(300, FRAME_LEN, FRAME_LEN - 1, -1);
    join_none
    repeat (5) @(posedge clk);
    #1;
    check("t2_still_full", sink_ready, 0);
    ready_mode = 2;
    waited = 0;
    forever begin
      @(negedge clk);
      if (src_valid && src_ready && src_eop) break;
      waited++;
      if (waited > BUDGET) break;
    end
    check("t2_eop_seen", waited > BUDGET, 0);
    @(posedge clk);
    #1;
    check("t2_release_hold", sink_ready, 0);
    @(posedge clk);
    #1;
    check("t2_release_rise", sink_ready, 1);
    wait fork;
    wait_drain("t2_drain");
    check("t2_drop", drop_count, 0);
    ready_mode = 0;

    // Test 3: beats without sop are ignored silently.
    do_reset();
    for (int i = 0; i < 5; i++) send_beat(900 + i, 1'b0, 1'b0, 2'b00);
    push_frame(1000);
    send_frame(1000, FRAME_LEN, FRAME_LEN - 1, -1);
    wait_drain("t3_drain");
    check("t3_drop", drop_count, 0);

    // Test 4: early eop at beat 40 is dropped, next frame passes.
    do_reset();
    send_frame(1500, 41, 40, -1);
    push_frame(2000);
    send_frame(2000, FRAME_LEN, FRAME_LEN - 1, -1);
    wait_drain("t4_drain");
    check("t4_drop", drop_count, 1);

    // Test 5: error on beat 10, then a frame restarted by sop at beat 30.
    do_reset();
    send_frame(2500, FRAME_LEN, FRAME_LEN - 1, 10);
    send_frame(2700, 30, -1, -1);
    push_frame(3000);
    send_frame(3000, FRAME_LEN, FRAME_LEN - 1, -1);
    wait_drain("t5_drain");
    check("t5_drop", drop_count, 2);

    // Test 6: reset at output beat 20 with a second frame committed.
    do_reset();
    ready_mode = 1;
    push_frame(3500);
    push_frame(3600);
    send_frame(3500, FRAME_LEN, FRAME_LEN - 1, -1);
    send_frame(3600, FRAME_LEN, FRAME_LEN - 1, -1);
    ready_mode = 0;
    n = 0;
    waited = 0;
    forever begin
      @(negedge clk);
      if (src_valid && src_ready) begin
        if (n == 20) break;
        n++;
      end
      waited++;
      if (waited > BUDGET) break;
    end
    check("t6_reached_beat20", n, 20);
    do_reset();
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (src_valid) seen = 1'b1;
    end
    check("t6_no_residual", seen, 0);
    check("t6_drop", drop_count, 0);
    push_frame(3900);
    send_frame(3900, FRAME_LEN, FRAME_LEN - 1, -1);
    wait_drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_buffer.md
# fft_frame_buffer

Avalon-ST frame receiver that sits between the sample-framing front end and the FFT core. It accepts FRAME_LEN-sample frames on a sink port (valid/ready, sop/eop, error), checks the framing, and stores good frames in a two-bank ping-pong buffer. Stored frames are replayed on a source port with sop/eop under downstream backpressure, so the FFT only ever sees whole, well-formed frames.

## Interface
- DATA_W, 12, sample width in bits (signed two's complement, passed through unchanged)
- FRAME_LEN, 64, beats per frame; power of 2, ≥4; index width clog2(FRAME_LEN)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sink_valid  in  1  upstream beat valid
- sink_ready  out  1  block can accept a beat this cycle; registered
- sink_sop  in  1  first beat of frame
- sink_eop  in  1  last beat of frame
- sink_error  in  2  nonzero marks the beat, and therefore its frame, bad
- sink_data  in  DATA_W  sample
- src_valid  out  1  output beat valid; registered
- src_ready  in  1  downstream accepts beat
- src_sop  out  1  high on beat 0 of output frame
- src_eop  out  1  high on beat FRAME_LEN-1
- src_data  out  DATA_W  sample
- drop_count  out  8  frames discarded since reset; saturates at 255

## Operation
- Storage: two banks of FRAME_LEN×DATA_W. Each bank carries a committed flag. wr_bank points at the bank being filled; rd_bank points at the oldest committed bank. Both pointers toggle.
- Sink accept: a beat is taken on sink_valid && sink_ready. sink_ready = 1 iff bank[wr_bank] is not committed.
- Write FSM states:
  - W_HUNT: a beat without sop is discarded silently; drop_count is unchanged. An sop beat writes index 0 and moves to W_FILL with idx=1. An sop beat that is also eop, or has sink_error≠0, is a dropped frame.
  - W_FILL: each beat writes bank[wr_bank][idx], then idx++. A bad flag is set if sink_error≠0 on any beat.
    - sop seen mid-frame: drop the current frame, drop_count+1. The sop beat becomes index 0 of a new frame, and the FSM stays in W_FILL with idx=1.
    - eop with idx==FRAME_LEN-1 and no bad flag: commit the bank, toggle wr_bank, go to W_HUNT.
    - eop with idx≠FRAME_LEN-1, or eop with the bad flag set: drop the frame, drop_count+1, go to W_HUNT.
    - Beat at idx==FRAME_LEN-1 without eop: drop the frame, drop_count+1, go to W_HUNT.
  - Dropping a frame never commits the bank, and wr_bank is unchanged.
- Read FSM states:
  - R_IDLE: when bank[rd_bank] is committed, load beat 0 into the output registers with src_sop=1, and go to R_SEND.
  - R_SEND: on src_valid && src_ready, advance rd_idx and present the next beat. src_eop=1 when rd_idx==FRAME_LEN-1.
  - Acceptance of the eop beat: clear the committed flag and toggle rd_bank. If the other bank is committed, present its beat 0 on the next cycle (zero bubble). Otherwise go to R_IDLE with src_valid=0.
- While src_valid=1 and src_ready=0, src_data, src_sop and src_eop stay stable.
- Both banks committed: sink_ready=0. Incoming beats are not accepted, and nothing is lost.
- Simultaneous events: the read side freeing a bank and the write side committing the other bank in the same cycle are independent. No priority conflict arises, because the FSMs never address the same bank.

## Timing
- Reset asserted: sink_ready=0, src_valid=0, src_sop=0, src_eop=0, src_data=0, drop_count=0. Both committed flags are cleared, wr_bank=rd_bank=0, and both FSMs return to idle/hunt. This takes effect asynchronously.
- Reset asserted mid-frame (input or output): all partial and committed frames are discarded, and no residual beats appear after release.
- sink_ready rises at the first clk edge after reset deasserts.
- Commit latency: src_valid rises at the clk edge following the edge that accepted the sink eop beat (1 cycle).
- Bank release: the edge accepting the src eop beat clears the committed flag. sink_ready rises at the next edge if the writer was stalled on that bank.
- Throughput: 1 beat/cycle on each side when unstalled.
- drop_count updates on the edge that decides the drop.

## Test plan
- Clean frame, data 0..63, src_ready=1: src_valid rises 1 cycle after the eop beat; 64 output beats with data 0..63; sop on beat 0 only, eop on beat 63 only; drop_count=0.
- Three back-to-back frames, src_ready held 0: sink_ready=0 after the second eop. Then raise src_ready=1 / 0 on alternating cycles: src data is held while stalled, all 192 samples arrive in order, and sink_ready re-rises one cycle after frame 1's src eop is accepted.
- 5 beats without sop, then a clean frame: the 5 beats are absent from the output, the frame is output intact, and drop_count=0.
- Early eop at beat 40, then a clean frame: no output for the first, the second is output, drop_count=1.
- Two frames with faults: sink_error=2'b01 on beat 10, and a fresh sop at beat 30 of another frame. Both faulty frames are dropped, drop_count=2, and the restarted frame (sop at beat 30) outputs its 64 beats correctly.
- Reset asserted at output beat 20 with a second frame committed: src_valid=0 immediately. After release, sink_ready=1 on the first edge, no output until a new frame arrives, and drop_count=0.
